// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the mips_mem_host memory responder.
// Holds the loader/run/done state encoding used by the top.
package mips_mem_pkg;

  localparam int IW = 9;
  localparam int DW = 8;
  localparam int AW = 8;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sp_ram_async.sv
// Single write port RAM with NR asynchronous read ports.
// Write on the rising edge, reads are purely combinational.
module sp_ram_async #(
  parameter int W  = 8,
  parameter int A  = 8,
  parameter int NR = 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [A-1:0]         waddr,
  input  logic [W-1:0]         wdata,
  input  logic [NR-1:0][A-1:0] raddr,
  output logic [NR-1:0][W-1:0] rdata
);

  logic [W-1:0] mem [2**A];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      rdata[r] = mem[raddr[r]];
    end
  end

endmodule

// File: rtl/mips_mem_host.sv
// Instruction/data memory host for the 9-bit single-cycle core.
// Streams a program in, releases the core, freezes it at program end.
module mips_mem_host #(
  parameter int IW = mips_mem_pkg::IW,
  parameter int DW = mips_mem_pkg::DW,
  parameter int AW = mips_mem_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  output logic [IW-1:0] inst,
  input  logic          MemWrite,
  input  logic [AW-1:0] ALUOut,
  input  logic [DW-1:0] rd2_Data,
  output logic [DW-1:0] ReadData,
  output logic          core_rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_sel,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_err,
  output logic          done,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  import mips_mem_pkg::*;

  state_t state, state_n;

  logic [AW:0] i_ptr, d_ptr, prog_len, i_ptr_inc;
  logic        accept, i_beat, d_beat;
  logic        i_full, d_full, run_we;
  logic        im_we, dm_we;
  logic [AW-1:0] dm_waddr;
  logic [DW-1:0] dm_wdata;
  logic [1:0][AW-1:0] dm_raddr;
  logic [1:0][DW-1:0] dm_rdata;

  assign accept = ld_valid & ld_ready;
  assign i_beat = accept & ~ld_sel;
  assign d_beat = accept & ld_sel;
  assign i_full = i_ptr[AW];
  assign d_full = d_ptr[AW];
  assign im_we  = i_beat & ~i_full;
  assign run_we = (state == ST_RUN) & MemWrite & ~rst;

  // Post-increment pointer; prog_len is taken from this on ld_last.
  assign i_ptr_inc = i_ptr + {{AW{1'b0}}, im_we};

  always_comb begin
    dm_we    = 1'b0;
    dm_waddr = d_ptr[AW-1:0];
    dm_wdata = ld_data[DW-1:0];
    unique case (1'b1)
      run_we: begin
        dm_we    = 1'b1;
        dm_waddr = ALUOut;
        dm_wdata = rd2_Data;
      end
      d_beat:  dm_we = ~d_full;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_ptr    <= '0;
      d_ptr    <= '0;
      prog_len <= '0;
      ld_err   <= 1'b0;
    end else if (accept) begin
      i_ptr <= i_ptr_inc;
      if (d_beat & ~d_full) d_ptr <= d_ptr + (AW+1)'(1);
      if ((i_beat & i_full) | (d_beat & d_full)) ld_err <= 1'b1;
      if (ld_last) prog_len <= i_ptr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_LOAD: begin
        if (accept & ld_last)
          state_n = (i_ptr_inc == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if ({1'b0, pc} == prog_len) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_DONE;
      default: state_n = ST_LOAD;
    endcase
  end

  always_comb begin
    ld_ready = ~rst & (state == ST_LOAD);
    core_rst = rst | (state != ST_RUN);
    done     = (state == ST_DONE);
  end

  sp_ram_async #(.W(IW), .A(AW), .NR(1)) u_imem (
    .clk   (clk),
    .we    (im_we),
    .waddr (i_ptr[AW-1:0]),
    .wdata (ld_data),
    .raddr (pc),
    .rdata (inst)
  );

  assign dm_raddr[0] = ALUOut;
  assign dm_raddr[1] = dbg_addr;
  assign ReadData    = dm_rdata[0];
  assign dbg_data    = dm_rdata[1];

  sp_ram_async #(.W(DW), .A(AW), .NR(2)) u_dmem (
    .clk   (clk),
    .we    (dm_we),
    .waddr (dm_waddr),
    .wdata (dm_wdata),
    .raddr (dm_raddr),
    .rdata (dm_rdata)
  );

endmodule

// File: tb/tb_mips_mem_host.sv
// Directed bench for mips_mem_host: load, run, done, overflow,
// stall and reset scenarios with hand-computed expectations.
module tb_mips_mem_host;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pc;
  logic [8:0] inst;
  logic       MemWrite;
  logic [7:0] ALUOut;
  logic [7:0] rd2_Data;
  logic [7:0] ReadData;
  logic       core_rst;
  logic       ld_valid;
  logic       ld_ready;
  logic       ld_sel;
  logic [8:0] ld_data;
  logic       ld_last;
  logic       ld_err;
  logic       done;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_mem_host dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .inst     (inst),
    .MemWrite (MemWrite),
    .ALUOut   (ALUOut),
    .rd2_Data (rd2_Data),
    .ReadData (ReadData),
    .core_rst (core_rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_sel   (ld_sel),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_err   (ld_err),
    .done     (done),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic beat(input logic sel, input logic [8:0] d,
                      input logic last);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ld_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b want 0", ld_ready);
    end
    step();
    rst = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ld_ready, core_rst, done, ld_err} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_state: rdy/crst/done/err got %b want 1100",
               {ld_ready, core_rst, done, ld_err});
    end
  endtask

  task automatic test_load_run();
    step();
    beat(1'b0, 9'h001, 1'b0);
    beat(1'b0, 9'h002, 1'b0);
    beat(1'b0, 9'h003, 1'b0);
    ld_valid = 1'b1;
    ld_sel   = 1'b1;
    ld_data  = 9'h0AA;
    ld_last  = 1'b1;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b1) begin
      errors++;
      $display("FAIL crst_in_last_beat: got %b want 1", core_rst);
    end
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    pc       = 8'd0;
    dbg_addr = 8'd0;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b0) begin
      errors++;
      $display("FAIL crst_release: got %b want 0", core_rst);
    end
    checks++;
    if (inst !== 9'h001) begin
      errors++;
      $display("FAIL inst_pc0: got %h want 001", inst);
    end
    checks++;
    if (dbg_data !== 8'hAA) begin
      errors++;
      $display("FAIL dbg_d0: got %h want aa", dbg_data);
    end
    step();
    MemWrite = 1'b1;
    ALUOut   = 8'h10;
    rd2_Data = 8'h5C;
    step();
    MemWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (ReadData !== 8'h5C) begin
      errors++;
      $display("FAIL run_store: got %h want 5c", ReadData);
    end
    step();
    pc = 8'd1;
    @(negedge clk);
    checks++;
    if (inst !== 9'h002) begin
      errors++;
      $display("FAIL inst_pc1: got %h want 002", inst);
    end
    step();
    pc = 8'd2;
    @(negedge clk);
    checks++;
    if ({inst, done} !== {9'h003, 1'b0}) begin
      errors++;
      $display("FAIL inst_pc2: inst/done got %h/%b want 003/0",
               inst, done);
    end
    step();
    pc       = 8'd3;
    MemWrite = 1'b1;
    ALUOut   = 8'h20;
    rd2_Data = 8'h77;
    @(negedge clk);
    checks++;
    if ({done, core_rst} !== 2'b00) begin
      errors++;
      $display("FAIL detect_cycle: done/crst got %b want 00",
               {done, core_rst});
    end
    step();
    MemWrite = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, core_rst, ld_ready} !== 3'b110) begin
      errors++;
      $display("FAIL done_entry: done/crst/rdy got %b want 110",
               {done, core_rst, ld_ready});
    end
    checks++;
    if (ReadData !== 8'h77) begin
      errors++;
      $display("FAIL detect_store: got %h want 77", ReadData);
    end
    step();
    MemWrite = 1'b1;
    rd2_Data = 8'h11;
    step();
    MemWrite = 1'b0;
    @(negedge clk);
    checks++;
    if ({ReadData, done} !== {8'h77, 1'b1}) begin
      errors++;
      $display("FAIL done_store_ignored: rd/done got %h/%b want 77/1",
               ReadData, done);
    end
  endtask

  task automatic test_load_store_ignored();
    step();
    do_reset();
    MemWrite = 1'b1;
    ALUOut   = 8'h10;
    rd2_Data = 8'hEE;
    step();
    MemWrite = 1'b0;
    dbg_addr = 8'h10;
    @(negedge clk);
    checks++;
    if ({dbg_data, ld_ready} !== {8'h5C, 1'b1}) begin
      errors++;
      $display("FAIL load_store_ignored: dbg/rdy got %h/%b want 5c/1",
               dbg_data, ld_ready);
    end
  endtask

  task automatic test_dmem_only();
    step();
    beat(1'b1, 9'h033, 1'b1);
    dbg_addr = 8'd0;
    @(negedge clk);
    checks++;
    if ({done, core_rst, ld_ready} !== 3'b110) begin
      errors++;
      $display("FAIL dmem_only_done: done/crst/rdy got %b want 110",
               {done, core_rst, ld_ready});
    end
    checks++;
    if (dbg_data !== 8'h33) begin
      errors++;
      $display("FAIL dmem_only_data: got %h want 33", dbg_data);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      checks++;
      if (core_rst !== 1'b1) begin
        errors++;
        $display("FAIL dmem_only_hold: cyc %0d got %b want 1",
                 k, core_rst);
      end
    end
  endtask

  task automatic test_overflow();
    step();
    do_reset();
    for (int k = 0; k < 257; k++) begin
      beat(1'b0, 9'(k + 1), 1'b0);
      if (k == 255) begin
        checks++;
        if (ld_err !== 1'b0) begin
          errors++;
          $display("FAIL ovf_err_early: got %b want 0", ld_err);
        end
      end
    end
    pc = 8'd255;
    @(negedge clk);
    checks++;
    if ({ld_err, ld_ready} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_err: err/rdy got %b want 11",
               {ld_err, ld_ready});
    end
    checks++;
    if (inst !== 9'h100) begin
      errors++;
      $display("FAIL ovf_last_stored: got %h want 100", inst);
    end
    step();
    pc = 8'd0;
    @(negedge clk);
    checks++;
    if (inst !== 9'h001) begin
      errors++;
      $display("FAIL ovf_no_wrap: got %h want 001", inst);
    end
  endtask

  task automatic test_stall();
    step();
    do_reset();
    beat(1'b0, 9'h0A1, 1'b0);
    beat(1'b0, 9'h0A2, 1'b0);
    ld_sel  = 1'b0;
    ld_data = 9'h1FF;
    for (int k = 0; k < 5; k++) step();
    pc = 8'd2;
    @(negedge clk);
    checks++;
    if (inst !== 9'h003) begin
      errors++;
      $display("FAIL stall_no_write: got %h want 003", inst);
    end
    step();
    beat(1'b0, 9'h0A3, 1'b0);
    @(negedge clk);
    checks++;
    if (inst !== 9'h0A3) begin
      errors++;
      $display("FAIL stall_ptr_hold: got %h want 0a3", inst);
    end
    step();
    pc = 8'd3;
    @(negedge clk);
    checks++;
    if (inst !== 9'h004) begin
      errors++;
      $display("FAIL stall_next_intact: got %h want 004", inst);
    end
  endtask

  task automatic test_rst_mid();
    step();
    do_reset();
    beat(1'b0, 9'h0C1, 1'b0);
    do_reset();
    pc = 8'd0;
    beat(1'b0, 9'h005, 1'b0);
    beat(1'b0, 9'h006, 1'b0);
    beat(1'b1, 9'h099, 1'b1);
    dbg_addr = 8'd0;
    @(negedge clk);
    checks++;
    if ({core_rst, inst} !== {1'b0, 9'h005}) begin
      errors++;
      $display("FAIL rst_mid_load_restart: crst/inst got %b/%h want 0/005",
               core_rst, inst);
    end
    step();
    do_reset();
    @(negedge clk);
    checks++;
    if ({core_rst, done, ld_ready} !== 3'b101) begin
      errors++;
      $display("FAIL rst_mid_run: crst/done/rdy got %b want 101",
               {core_rst, done, ld_ready});
    end
    checks++;
    if (dbg_data !== 8'h99) begin
      errors++;
      $display("FAIL rst_keeps_dmem: got %h want 99", dbg_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    pc       = 8'd0;
    MemWrite = 1'b0;
    ALUOut   = 8'd0;
    rd2_Data = 8'd0;
    ld_valid = 1'b0;
    ld_sel   = 1'b0;
    ld_data  = 9'd0;
    ld_last  = 1'b0;
    dbg_addr = 8'd0;
    test_reset();
    test_load_run();
    test_load_store_ignored();
    test_dmem_only();
    test_overflow();
    test_stall();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
